mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported instruction/data memory between three requesters: instruction fetch (feeds cmdIn/cmdPush of
//  the fetch unit), data load/store (sysMode 01 phase), and a debug/program loader. One transaction in flight at a time;
//  handles memory wait states, per-access timeout, and returns read data on one registered response bus.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  TMO      15  max wait cycles for mem_ready before abort (4-bit counter; must be 1..15)
// PORTS
//  clk        in   1   clock, rising edge
//  nrst       in   1   asynchronous reset, active low
//  if_req     in   1   fetch read request, level, held until if_ack
//  if_addr    in   AW  fetch address (PC)
//  d_req      in   1   data request, level, held until d_ack
//  d_we       in   1   1=store, 0=load
//  d_addr     in   AW  data address;      d_wdata in DW store data
//  dbg_req    in   1   loader request, level, held until dbg_ack
//  dbg_we     in   1   1=write, 0=read;   dbg_addr in AW; dbg_wdata in DW
//  if_ack     out  1   1-cycle pulse, rsp_rdata valid (drives fetch cmdPush)
//  d_ack      out  1   1-cycle pulse, load data valid / store done
//  dbg_ack    out  1   1-cycle pulse, loader access done
//  rsp_rdata  out  DW  registered read data, held until next response (drives fetch cmdIn)
//  rsp_err    out  1   high with the ack pulse when access timed out
//  mem_req    out  1   memory request, held until mem_ready
//  mem_we     out  1   memory write enable; mem_addr out AW; mem_wdata out DW
//  mem_rdata  in   DW  memory read data, valid when mem_ready
//  mem_ready  in   1   memory completes access this cycle
//  busy       out  1   transaction in flight (state != IDLE)
// BEHAVIOUR
//  Reset (nrst=0, async, any state): state=IDLE, all acks 0, rsp_err 0, rsp_rdata 0, mem_req 0, mem_we 0,
//   mem_addr/mem_wdata 0, busy 0, rr_last=FETCH, wait counter 0. In-flight access is abandoned, no ack issued.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if any req, select winner, latch addr/we/wdata into mem_* regs, mem_req=1 next cycle, go ACCESS.
//   ACCESS: mem_req held, mem_* stable. On mem_ready: capture mem_rdata (reads only; writes leave rsp_rdata unchanged),
//    drop mem_req, go RESP. Counter increments each ACCESS cycle without mem_ready; when it reaches TMO: drop mem_req,
//    rsp_rdata=0, rsp_err=1, go RESP.
//   RESP: winner's ack=1 for exactly this cycle (rsp_err with it); go IDLE. rsp_err cleared in IDLE.
//  Latency: req seen in IDLE -> mem_req next edge; mem_ready with 0 wait -> ack 2 cycles after mem_req rise.
//   Min request-to-ack 3 cycles; back-to-back throughput 1 access / 3 cycles.
//  Arbitration (evaluated only in IDLE): dbg strict highest priority. Between d and if: round-robin via rr_last;
//   if both request, grant the one not granted last; rr_last updated on every d/if grant. dbg never preempts
//   an access in flight.
//  Requester deasserting req before ack: access still completes on memory; ack still pulses (protocol violation,
//   not masked). Req held after ack is a new request and re-arbitrated in IDLE.
//  mem_ready while not in ACCESS: ignored. fetch is always read: mem_we=0 for if grants regardless of other inputs.
//  Addresses/data passed through unmodified; no width conversion or alignment checks.
// STRUCTURE
//  Shared package (cpu_pkg): state encodings ST_IDLE/ST_ACCESS/ST_RESP, requester IDs REQ_IF/REQ_D/REQ_DBG,
//   AW/DW defaults. One sub-module natural: rr_prio_arb (3-input, fixed-top + 2-way round-robin, combinational
//   grant + rr_last register). Rest (FSM, mux/latch, timeout counter) stays in this module.
// TESTING
//  1 reset: nrst=0 mid-ACCESS with mem_req=1 -> mem_req=0, busy=0 immediately, no ack after release.
//  2 fetch read: if_req, if_addr=0x10, mem_ready 1 cycle after mem_req, mem_rdata=0xC9000002 -> if_ack pulse,
//    rsp_rdata=0xC9000002, rsp_err=0, mem_we=0 throughout.
//  3 contention: if_req and d_req held together for 4 accesses -> grants alternate if,d,if,d; then dbg_req raised
//    during a d access -> d completes, dbg granted next ahead of pending if.
//  4 store with waits: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ready after 5 waits -> mem_* stable 6 cycles,
//    d_ack once, rsp_rdata unchanged.
//  5 timeout: mem_ready never asserted -> mem_req drops after TMO=15 cycles, ack with rsp_err=1, rsp_rdata=0; next
//    request proceeds normally.
//  6 stray mem_ready in IDLE/RESP -> no state change, no extra ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory port arbiter slice.
// States and requester ids are common to the top and the arbiter.
package cpu_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_IF  = 2'd0,
    REQ_D   = 2'd1,
    REQ_DBG = 2'd2
  } req_id_t;

endpackage

// File: rtl/rr_prio_arb.sv
// Three-way grant: debug on top, fetch/data share by round-robin.
// rr_last remembers the last fetch/data winner.
module rr_prio_arb
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    nrst,
  input  logic    en,
  input  logic    if_req,
  input  logic    d_req,
  input  logic    dbg_req,
  output logic    gnt_vld,
  output req_id_t gnt_id
);

  req_id_t rr_last;
  logic    pick_d;

  assign gnt_vld = if_req | d_req | dbg_req;

  // data wins if alone, or if fetch had the last turn
  assign pick_d = !dbg_req && d_req &&
                  (!if_req || rr_last == REQ_IF);

  always_comb begin
    gnt_id = REQ_IF;
    unique case (1'b1)
      dbg_req: gnt_id = REQ_DBG;
      pick_d:  gnt_id = REQ_D;
      default: gnt_id = REQ_IF;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_last <= REQ_IF;
    end else if (en && gnt_vld && gnt_id != REQ_DBG) begin
      rr_last <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch, data and debug loader.
// One access in flight: IDLE -> ACCESS -> RESP, with wait-state timeout.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          if_ack,
  output logic          d_ack,
  output logic          dbg_ack,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  state_t        state;
  state_t        state_nx;
  req_id_t       owner;
  req_id_t       gnt_id;
  logic          gnt_vld;
  logic          arb_en;
  logic          done;
  logic          abort;
  logic [3:0]    cnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_prio_arb u_arb (
    .clk     (clk),
    .nrst    (nrst),
    .en      (arb_en),
    .if_req  (if_req),
    .d_req   (d_req),
    .dbg_req (dbg_req),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    arb_en   = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (gnt_vld) state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          done     = 1'b1;
          state_nx = ST_RESP;
        end else if (cnt == TMO_LAST) begin
          abort    = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // fetch never writes, whatever the store inputs say
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = if_addr;
    sel_wdata = '0;
    unique case (gnt_id)
      REQ_DBG: begin
        sel_we    = dbg_we;
        sel_addr  = dbg_addr;
        sel_wdata = dbg_wdata;
      end
      REQ_D: begin
        sel_we    = d_we;
        sel_addr  = d_addr;
        sel_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner     <= REQ_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (arb_en && gnt_vld) begin
        owner     <= gnt_id;
        mem_req   <= 1'b1;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (state == ST_ACCESS) begin
        if (done) begin
          mem_req <= 1'b0;
          cnt     <= '0;
          if (!mem_we) rsp_rdata <= mem_rdata;
        end else if (abort) begin
          mem_req   <= 1'b0;
          cnt       <= '0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      if (state == ST_RESP) rsp_err <= 1'b0;
    end
  end

  assign if_ack  = (state == ST_RESP) && (owner == REQ_IF);
  assign d_ack   = (state == ST_RESP) && (owner == REQ_D);
  assign dbg_ack = (state == ST_RESP) && (owner == REQ_DBG);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
// A small memory model answers mem_req after a programmable wait.
module tb_mem_port_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        if_req, d_req, d_we, dbg_req, dbg_we;
  logic [31:0] if_addr, d_addr, d_wdata, dbg_addr, dbg_wdata;
  logic        if_ack, d_ack, dbg_ack, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   vecs = 0;
  int   fails = 0;
  int   ack_cnt = 0;
  int   req_cycles = 0;
  int   wait_n = 0;
  int   wcnt = 0;
  int   cyc;
  int   a0;
  logic resp_on = 1'b1;
  logic stray = 1'b0;
  logic mem_chk = 1'b0;
  logic chk_wd = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .nrst      (nrst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .if_ack    (if_ack),
    .d_ack     (d_ack),
    .dbg_ack   (dbg_ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  function automatic logic [31:0] rd_of(logic [31:0] a);
    if (a == 32'h10) return 32'hC900_0002;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [1:0] id, logic [31:0] rd, logic err);
    exp_t e;
    e.id = id;
    e.rdata = rd;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_acks(int n, int budget, output int used);
    int t;
    t = ack_cnt + n;
    used = 0;
    while (ack_cnt < t && used < budget) begin
      @(posedge clk);
      #1;
      used++;
    end
    chk("ack_arrived", 32'(ack_cnt >= t), 32'd1);
  endtask

  // memory model: ready after wait_n wait cycles, or always when stray
  always @(negedge clk) begin
    mem_rdata = mem_req ? rd_of(mem_addr) : 32'hBAD0_BAD0;
    mem_ready = stray;
    if (mem_req && resp_on && !stray) begin
      if (wcnt == wait_n) begin
        mem_ready = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else if (!mem_req) begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      if (mem_req) req_cycles++;
      if (mem_req && mem_chk) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        if (chk_wd) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (if_ack | d_ack | dbg_ack) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          chk("extra_ack", 32'({dbg_ack, d_ack, if_ack}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_id", 32'({dbg_ack, d_ack, if_ack}), 32'(3'b001 << e.id));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    nrst = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    if_req = 0; d_req = 0; dbg_req = 0;
    d_we = 0; dbg_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    dbg_addr = '0; dbg_wdata = '0;
    exp_we = 0; exp_addr = '0; exp_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack, dbg_ack}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    nrst = 1'b1;

    // reset during an access that never completes
    resp_on = 1'b0;
    if_addr = 32'h40;
    if_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    #3;
    nrst = 1'b0;
    #1;
    chk("t1_async_req", 32'(mem_req), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    resp_on = 1'b1;
    a0 = ack_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("t1_no_ack", 32'(ack_cnt), 32'(a0));
    chk("t1_idle", 32'(busy), 32'd0);

    // fetch read, no wait states
    d_we = 1'b1;
    if_addr = 32'h10;
    exp_we = 1'b0;
    exp_addr = 32'h10;
    chk_wd = 1'b0;
    mem_chk = 1'b1;
    req_cycles = 0;
    push(2'd0, 32'hC900_0002, 1'b0);
    if_req = 1'b1;
    wait_acks(1, 20, cyc);
    if_req = 1'b0;
    mem_chk = 1'b0;
    chk("t2_latency", 32'(cyc), 32'd3);
    chk("t2_req_cycles", 32'(req_cycles), 32'd1);

    // store with 5 wait states
    wait_n = 5;
    d_we = 1'b1;
    d_addr = 32'h200;
    d_wdata = 32'hDEAD_BEEF;
    exp_we = 1'b1;
    exp_addr = 32'h200;
    exp_wdata = 32'hDEAD_BEEF;
    chk_wd = 1'b1;
    mem_chk = 1'b1;
    req_cycles = 0;
    push(2'd1, 32'hC900_0002, 1'b0);
    d_req = 1'b1;
    wait_acks(1, 30, cyc);
    d_req = 1'b0;
    mem_chk = 1'b0;
    chk("t4_req_cycles", 32'(req_cycles), 32'd6);
    chk("t4_rdata_held", rsp_rdata, 32'hC900_0002);
    wait_n = 0;

    // fetch/data contention, then debug jumps ahead of pending fetch
    d_we = 1'b0;
    if_addr = 32'h20;
    d_addr = 32'h100;
    dbg_we = 1'b0;
    dbg_addr = 32'h300;
    push(2'd0, rd_of(32'h20), 1'b0);
    push(2'd1, rd_of(32'h100), 1'b0);
    push(2'd0, rd_of(32'h20), 1'b0);
    push(2'd1, rd_of(32'h100), 1'b0);
    push(2'd2, rd_of(32'h300), 1'b0);
    push(2'd0, rd_of(32'h20), 1'b0);
    if_req = 1'b1;
    d_req = 1'b1;
    wait_acks(3, 30, cyc);
    @(posedge clk);
    #1;
    chk("t3_d_inflight", mem_addr, 32'h100);
    chk("t3_d_req", 32'(mem_req), 32'd1);
    dbg_req = 1'b1;
    wait_acks(1, 20, cyc);
    d_req = 1'b0;
    wait_acks(1, 20, cyc);
    dbg_req = 1'b0;
    wait_acks(1, 20, cyc);
    if_req = 1'b0;

    // timeout on a load
    resp_on = 1'b0;
    d_addr = 32'h400;
    req_cycles = 0;
    push(2'd1, 32'd0, 1'b1);
    d_req = 1'b1;
    wait_acks(1, 40, cyc);
    d_req = 1'b0;
    resp_on = 1'b1;
    chk("t5_req_cycles", 32'(req_cycles), 32'd15);
    chk("t5_rdata_zero", rsp_rdata, 32'd0);
    if_addr = 32'h14;
    push(2'd0, rd_of(32'h14), 1'b0);
    if_req = 1'b1;
    wait_acks(1, 20, cyc);
    if_req = 1'b0;
    chk("t5_err_clear", 32'(rsp_err), 32'd0);

    // stray mem_ready in IDLE and RESP
    a0 = ack_cnt;
    stray = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_acks", 32'(ack_cnt), 32'(a0));
    chk("t6_idle_rdata", rsp_rdata, rd_of(32'h14));
    dbg_we = 1'b1;
    dbg_addr = 32'h500;
    dbg_wdata = 32'h1234_5678;
    push(2'd2, rd_of(32'h14), 1'b0);
    dbg_req = 1'b1;
    wait_acks(1, 20, cyc);
    dbg_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    stray = 1'b0;
    chk("t6_one_ack", 32'(ack_cnt), 32'(a0 + 1));
    chk("t6_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
